// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 post-adder multi-precision sequencer.
package dsp48a1_pkg;
    localparam int LIMB_W = 48;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/post_addsub_seq_if.sv
// Request/result handshake bundle for the multi-precision post-adder sequencer.
interface post_addsub_seq_if #(
    parameter int LIMBS = 2
);
    import dsp48a1_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [LIMB_W*LIMBS-1:0]   a;
    logic [LIMB_W*LIMBS-1:0]   b;
    logic                      add_subb;
    logic                      carryin;
    logic                      out_valid;
    logic                      out_ready;
    logic [LIMB_W*LIMBS-1:0]   result;
    logic                      carryout;
    logic                      busy;

    modport master (
        output in_valid, a, b, add_subb, carryin, out_ready,
        input  in_ready, out_valid, result, carryout, busy
    );

    modport slave (
        input  in_valid, a, b, add_subb, carryin, out_ready,
        output in_ready, out_valid, result, carryout, busy
    );
endinterface

// File: rtl/post_addsub_seq_adder.sv
// 48-bit post adder/subtractor; cout is carry for add and borrow for subtract.
module post_addsub_seq_adder
    import dsp48a1_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    input  logic              add_subb,
    output logic [LIMB_W-1:0] r,
    output logic              cout
);
    logic [LIMB_W:0] sum;

    // 49-bit arithmetic: in subtract mode bit 48 is set exactly on borrow
    always_comb begin
        if (add_subb == ADD)
            sum = {1'b0, b} + {1'b0, a} + {{LIMB_W{1'b0}}, cin};
        else
            sum = {1'b0, b} - {1'b0, a} - {{LIMB_W{1'b0}}, cin};
    end

    assign {cout, r} = sum;
endmodule

// File: rtl/post_addsub_seq.sv
// Sequences a LIMBS x 48-bit add/subtract through one shared post adder, LSB limb first.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high, last result held
//   RUN   | processing limb cnt, carry/borrow chained through c
//   DONE  | result and carryout presented until out_ready
module post_addsub_seq
    import dsp48a1_pkg::*;
#(
    parameter int LIMBS = 2
) (
    input  logic              clk,
    input  logic              rst,
    post_addsub_seq_if.slave  bus
);
    localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMBS - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]              cnt;
    logic                          c;
    logic                          mode_q;
    logic                          cout_q;
    logic [LIMBS-1:0][LIMB_W-1:0]  a_q;
    logic [LIMBS-1:0][LIMB_W-1:0]  b_q;
    logic [LIMBS-1:0][LIMB_W-1:0]  res_q;
    logic [LIMB_W-1:0]             sum_r;
    logic                          sum_c;

    post_addsub_seq_adder u_adder (
        .a        (a_q[cnt]),
        .b        (b_q[cnt]),
        .cin      (c),
        .add_subb (mode_q),
        .r        (sum_r),
        .cout     (sum_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results stay in place after DONE; a new operation overwrites them limb by limb
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            c      <= 1'b0;
            mode_q <= 1'b0;
            cout_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        mode_q <= bus.add_subb;
                        c      <= bus.carryin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    res_q[cnt] <= sum_r;
                    c          <= sum_c;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) cout_q <= sum_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = res_q;
    assign bus.carryout  = cout_q;
endmodule

// File: tb/tb_post_addsub_seq.sv
// Directed bench for the two-limb multi-precision post-adder sequencer.
module tb_post_addsub_seq;
    import dsp48a1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    post_addsub_seq_if #(.LIMBS(2)) bus ();

    post_addsub_seq #(.LIMBS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [95:0] ONES = {96{1'b1}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation with hand-computed expectations; inputs are scrambled after accept
    task automatic do_op(input string tag, input logic [95:0] av, input logic [95:0] bv,
                         input logic mode, input logic cin,
                         input logic [95:0] exp_r, input logic exp_c);
        bus.a        = av;
        bus.b        = bv;
        bus.add_subb = mode;
        bus.carryin  = cin;
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready_idle"}, 128'(bus.in_ready), 128'(1'b1));
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~av;
        bus.b        = ~bv;
        bus.add_subb = ~mode;
        bus.carryin  = ~cin;
        chk({tag, ".busy"}, 128'({bus.busy, bus.in_ready, bus.out_valid}), 128'(3'b100));
        tick();
        chk({tag, ".no_early_valid"}, 128'(bus.out_valid), 128'(1'b0));
        tick();
        chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(1'b1));
        chk({tag, ".result"}, 128'(bus.result), 128'(exp_r));
        chk({tag, ".carryout"}, 128'(bus.carryout), 128'(exp_c));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".back_idle"}, 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));
        chk({tag, ".held"}, 128'({bus.carryout, bus.result}), 128'({exp_c, exp_r}));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.add_subb  = ADD;
        bus.carryin   = 1'b0;
        bus.out_ready = 1'b0;

        #1;
        chk("reset.outputs", 128'({bus.in_ready, bus.out_valid, bus.busy, bus.carryout}),
            128'(4'b1000));
        chk("reset.result", 128'(bus.result), 128'(0));
        tick();
        rst = 1'b0;
        tick();

        do_op("add_carry", {48'h0, 48'hFFFF_FFFF_FFFF}, {48'h0, 48'h1}, ADD, 1'b0,
              {48'h1, 48'h0}, 1'b0);
        do_op("sub_borrow", {48'h0, 48'h1}, {48'h1, 48'h0}, SUB, 1'b0,
              {48'h0, 48'hFFFF_FFFF_FFFF}, 1'b0);
        do_op("sub_neg", 96'h1, 96'h0, SUB, 1'b0, ONES, 1'b1);
        do_op("sub_neg_cin", 96'h1, 96'h0, SUB, 1'b1, {{95{1'b1}}, 1'b0}, 1'b1);
        do_op("add_full", ONES, ONES, ADD, 1'b1, ONES, 1'b1);
        do_op("add_mixed", {48'h0000_0000_0003, 48'h8000_0000_0000},
              {48'h0000_0000_0004, 48'h8000_0000_0001}, ADD, 1'b1,
              {48'h0000_0000_0008, 48'h0000_0000_0002}, 1'b0);

        // Backpressure: finish an op, then hold out_ready low while a new request waits
        bus.a = {48'h0, 48'h5}; bus.b = {48'h0, 48'h7};
        bus.add_subb = ADD; bus.carryin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("bp.first_done", 128'({bus.out_valid, bus.result}), 128'({1'b1, 48'h0, 48'hC}));
        bus.a = {48'h0, 48'h10}; bus.b = {48'h0, 48'h30};
        bus.add_subb = SUB; bus.carryin = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.stall", 128'({bus.out_valid, bus.in_ready, bus.carryout, bus.result}),
                128'({1'b1, 1'b0, 1'b0, 48'h0, 48'hC}));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp.released", 128'({bus.in_ready, bus.out_valid}), 128'(2'b10));
        tick();
        bus.in_valid = 1'b0;
        chk("bp.accepted", 128'({bus.busy, bus.in_ready}), 128'(2'b10));
        tick();
        tick();
        chk("bp.second", 128'({bus.out_valid, bus.carryout, bus.result}),
            128'({1'b1, 1'b0, 48'h0, 48'h1F}));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset right after limb 0 has been processed
        bus.a = ONES; bus.b = ONES; bus.add_subb = ADD; bus.carryin = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid.outputs", 128'({bus.in_ready, bus.out_valid, bus.busy, bus.carryout}),
            128'(4'b1000));
        chk("rst_mid.result", 128'(bus.result), 128'(0));
        tick();
        chk("rst_mid.no_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid.still_idle", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
        do_op("post_rst", {48'h0, 48'h5}, {48'h0, 48'h7}, ADD, 1'b0, {48'h0, 48'hC}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/post_addsub_seq.md
# post_addsub_seq

Multi-precision add/subtract sequencer for the post-adder stage of the DSP48A1 datapath. It accepts one LIMBS×48-bit operation over a valid/ready handshake and drives a single shared 48-bit post adder/subtractor once per cycle, least-significant limb first. The carry or borrow is chained between limbs through a register. The wide result and the final carry-out are returned over a second valid/ready handshake. The block sits between the pre-adder/multiplier result path and the P register stage. It lets the 48-bit post adder serve wider accumulations without replicating it.

## Interface
- LIMBS, default 2: number of 48-bit limbs; legal range 1–8.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block can accept a request; high only in IDLE.
- A  in  48*LIMBS  operand A; limb i is bits [48i+47:48i].
- B  in  48*LIMBS  operand B; same limb layout as A.
- ADD_SUBB  in  1  0 selects B+A+CARRYIN; 1 selects B−A−CARRYIN.
- CARRYIN  in  1  carry-in (add) or borrow-in (subtract) for limb 0.
- OUT_VALID  out  1  RESULT and CARRYOUT are valid.
- OUT_READY  in  1  consumer accepts the result.
- RESULT  out  48*LIMBS  wide result.
- CARRYOUT  out  1  carry (add) or borrow (subtract) out of the top limb.
- BUSY  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: IN_READY=1.
  - RUN: processes the limb selected by counter cnt, 0..LIMBS−1.
  - DONE: OUT_VALID=1.
- IDLE→RUN on IN_VALID&IN_READY:
  - latch A, B, ADD_SUBB and CARRYIN;
  - set cnt=0 and carry register c=CARRYIN.
- Each RUN cycle:
  - feed the shared adder with a=A[cnt], b=B[cnt], cin=c, add_subb=latched mode;
  - write RESULT[cnt]=adder result and c=adder cout;
  - increment cnt.
- Adder semantics:
  - add: {cout,r} = a+b+cin;
  - subtract: {cout,r} = b−a−cin, 49-bit two's complement, so cout=1 means borrow.
  - The same chaining rule (next cin = cout) therefore holds for both modes.
- RUN→DONE on the edge that processes limb LIMBS−1; CARRYOUT takes that limb's cout.
- DONE→IDLE on OUT_VALID&OUT_READY.
- Wide results, with N = 48·LIMBS:
  - add: RESULT = (A+B+CARRYIN) mod 2^N, CARRYOUT = bit N of the sum.
  - subtract: RESULT = (B−A−CARRYIN) mod 2^N, CARRYOUT=1 iff B < A+CARRYIN (unsigned).
- Inputs are ignored outside IDLE. A, B and mode changing mid-operation have no effect.
- RESULT and CARRYOUT are held stable in DONE and also in IDLE until the next operation overwrites them limb by limb.
- Reset (asynchronous, at any time including mid-RUN): state=IDLE, cnt=0, c=0, RESULT=0, CARRYOUT=0, OUT_VALID=0, BUSY=0, IN_READY=1. The partial operation is discarded.

## Timing
- Accept on edge k → limbs 0..LIMBS−1 processed on edges k+1..k+LIMBS → OUT_VALID high after edge k+LIMBS.
- Latency is LIMBS cycles; it is LIMBS=1 for a single limb.
- IN_READY falls after edge k. It rises the cycle after the output handshake edge.
- There is no same-cycle output-to-input bypass. Peak throughput is one operation per LIMBS+2 cycles.
- OUT_VALID stays high with stable data until OUT_READY. Backpressure is unbounded.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Structure
- Shared package (dsp48a1_pkg):
  - LIMB_W=48;
  - state enum {IDLE, RUN, DONE};
  - mode constants ADD=0, SUB=1.
- One sub-module instance: the existing 48-bit post adder/subtractor, instantiated once and fed by limb muxes on cnt.
- The top level contains the FSM, the cnt counter, the carry register and the operand/result registers.

## Test plan
All scenarios use LIMBS=2.
- Add with limb carry: A={0,0xFFFFFFFFFFFF}, B={0,1}, CARRYIN=0, ADD_SUBB=0 → RESULT={1,0}, CARRYOUT=0. OUT_VALID exactly 2 edges after accept.
- Subtract with limb borrow: B={1,0}, A={0,1}, ADD_SUBB=1 → RESULT={0,0xFFFFFFFFFFFF}, CARRYOUT=0.
- Negative subtract: B=0, A=1, CARRYIN=0 → RESULT=all-ones (96 bits), CARRYOUT=1. With CARRYIN=1 → RESULT=all-ones−1, CARRYOUT=1.
- Full overflow: A=B=all-ones, CARRYIN=1, add → RESULT=all-ones, CARRYOUT=1.
- Backpressure: OUT_READY=0 for 5 cycles while IN_VALID=1 with new operands → RESULT, CARRYOUT and OUT_VALID stable, IN_READY=0, new request not taken. OUT_READY=1 → IDLE next cycle, then the new request is accepted.
- Reset after limb 0 of an operation → all outputs at reset values immediately, no OUT_VALID pulse. After release, a fresh add {0,5}+{0,7} gives {0,12}.
